// File: rtl/mega_ram_arb_pkg.sv
`default_nettype none
// mega_ram_arb_pkg: shared mode and port-select encodings for the mega_ram arbiter.
// Revision: 1.0
package mega_ram_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mega_ram_arb_sel.sv
`default_nettype none
// mega_ram_arb_sel: pure priority selection between port A and port B.
// Revision: 1.0
module mega_ram_arb_sel
    import mega_ram_arb_pkg::*;
(
    input  logic      a_req,
    input  logic      b_req,
    input  arb_mode_e mode,
    input  logic      rr_last,
    input  logic      starve_hit,
    output logic      win_valid,
    output logic      win_port
);

    always_comb begin
        win_valid = a_req | b_req;
        win_port  = PORT_A;
        if (a_req && b_req) begin
            if (mode == ARB_RR) begin
                win_port = ~rr_last;
            end else if (starve_hit) begin
                win_port = PORT_B;
            end
        end else if (b_req) begin
            win_port = PORT_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mega_ram_arbiter.sv
`default_nettype none
// mega_ram_arbiter: two-port arbiter in front of one mega_ram with a 1-cycle registered read.
// Revision: 1.0
module mega_ram_arbiter
    import mega_ram_arb_pkg::*;
#(
    parameter int    ADDR_BUS_WIDTH = 13,
    parameter int    DATA_BUS_WIDTH = 8,
    parameter string ARB_MODE       = "FIXED",
    parameter int    STARVE_LIMIT   = 8,
    parameter int    CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [ADDR_BUS_WIDTH-1:0] a_addr,
    input  logic [DATA_BUS_WIDTH-1:0] a_wdata,
    output logic                      a_gnt,
    output logic                      a_rvalid,
    output logic [DATA_BUS_WIDTH-1:0] a_rdata,
    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [ADDR_BUS_WIDTH-1:0] b_addr,
    input  logic [DATA_BUS_WIDTH-1:0] b_wdata,
    output logic                      b_gnt,
    output logic                      b_rvalid,
    output logic [DATA_BUS_WIDTH-1:0] b_rdata,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      ram_re,
    output logic [ADDR_BUS_WIDTH-1:0] ram_a,
    output logic [DATA_BUS_WIDTH-1:0] ram_d_in,
    input  logic [DATA_BUS_WIDTH-1:0] ram_d_out
);

    localparam arb_mode_e             MODE       = (ARB_MODE == "RR") ? ARB_RR : ARB_FIXED;
    localparam logic [CNT_WIDTH-1:0]  STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

    logic                 rd_pend;
    logic                 rd_owner;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 rr_last;

    logic win_valid;
    logic win_port;
    logic win_we;
    logic win_rd;
    logic b_win;
    logic starve_hit;

    assign starve_hit = (MODE == ARB_FIXED) && (STARVE_LIMIT != 0) && (wait_cnt == STARVE_MAX);

    mega_ram_arb_sel u_sel (
        .a_req      (a_req),
        .b_req      (b_req),
        .mode       (MODE),
        .rr_last    (rr_last),
        .starve_hit (starve_hit),
        .win_valid  (win_valid),
        .win_port   (win_port)
    );

    assign win_we = (win_port == PORT_B) ? b_we : a_we;
    assign win_rd = win_valid & ~win_we;
    assign b_win  = win_valid & (win_port == PORT_B);

    // Grants and RAM strobes are gated by reset so outputs fall to 0 as soon as rst_n drops
    assign a_gnt    = rst_n & win_valid & (win_port == PORT_A);
    assign b_gnt    = rst_n & b_win;
    assign ram_a    = b_win ? b_addr : a_addr;
    assign ram_d_in = b_win ? b_wdata : a_wdata;
    assign ram_we   = rst_n & win_valid & win_we;
    // The RAM gates d_out with cs&re, so both stay high through the return cycle
    assign ram_cs   = (rst_n & win_valid) | rd_pend;
    assign ram_re   = (rst_n & win_rd) | rd_pend;

    assign a_rvalid = rd_pend & (rd_owner == PORT_A);
    assign b_rvalid = rd_pend & (rd_owner == PORT_B);
    assign a_rdata  = a_rvalid ? ram_d_out : '0;
    assign b_rdata  = b_rvalid ? ram_d_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_A;
            wait_cnt <= '0;
            rr_last  <= PORT_B;
        end else begin
            rd_pend <= win_rd;
            if (win_rd) begin
                rd_owner <= win_port;
            end
            if ((MODE == ARB_FIXED) && b_req && !b_win) begin
                if (wait_cnt != STARVE_MAX) begin
                    wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                end
            end else begin
                wait_cnt <= '0;
            end
            if (win_valid && a_req && b_req) begin
                rr_last <= win_port;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mega_ram_arbiter.sv
`default_nettype none
// tb_mega_ram_arbiter: FIXED (limit 3) and RR arbiters checked every cycle against a behavioural model.
module tb_mega_ram_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int LIM = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_req [2], a_we [2], b_req [2], b_we [2];
    logic [AW-1:0] a_addr [2], b_addr [2], ram_a [2];
    logic [DW-1:0] a_wdata [2], b_wdata [2], a_rdata [2], b_rdata [2];
    logic [DW-1:0] ram_d_in [2], ram_d_out [2];
    logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
    logic          ram_cs [2], ram_we [2], ram_re [2];

    mega_ram_arbiter #(
        .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .ARB_MODE("FIXED"), .STARVE_LIMIT(LIM), .CNT_WIDTH(4)
    ) u_fixed (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
        .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
        .ram_cs(ram_cs[0]), .ram_we(ram_we[0]), .ram_re(ram_re[0]),
        .ram_a(ram_a[0]), .ram_d_in(ram_d_in[0]), .ram_d_out(ram_d_out[0])
    );

    mega_ram_arbiter #(
        .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .ARB_MODE("RR"), .STARVE_LIMIT(8), .CNT_WIDTH(4)
    ) u_rr (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
        .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
        .ram_cs(ram_cs[1]), .ram_we(ram_we[1]), .ram_re(ram_re[1]),
        .ram_a(ram_a[1]), .ram_d_in(ram_d_in[1]), .ram_d_out(ram_d_out[1])
    );

    // mega_ram stand-in: registered read, output gated by cs&re
    for (genvar i = 0; i < 2; i++) begin : g_ram
        logic [DW-1:0] mem [2**AW];
        logic [DW-1:0] q;
        always @(posedge clk) begin
            if (ram_cs[i] && ram_we[i]) mem[ram_a[i]] <= ram_d_in[i];
            if (ram_cs[i] && ram_re[i]) q <= mem[ram_a[i]];
        end
        assign ram_d_out[i] = (ram_cs[i] && ram_re[i]) ? q : '0;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: B wait streak, last contested winner (1=B), pending return, memory image
    int            m_wait [2];
    logic          m_last [2];
    logic          m_rv [2];
    logic          m_rb [2];
    logic [DW-1:0] m_rdat [2];
    logic [DW-1:0] m_mem [2][32];
    logic          sa [2], sb [2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] @%0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_check(input int k);
        logic          gv, wb, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        sa[k] = a_gnt[k];
        sb[k] = b_gnt[k];
        if (!rst_n) begin
            chk("rst_a_gnt", k, a_gnt[k], 0);       chk("rst_b_gnt", k, b_gnt[k], 0);
            chk("rst_a_rvalid", k, a_rvalid[k], 0); chk("rst_b_rvalid", k, b_rvalid[k], 0);
            chk("rst_a_rdata", k, a_rdata[k], 0);   chk("rst_b_rdata", k, b_rdata[k], 0);
            chk("rst_ram_cs", k, ram_cs[k], 0);     chk("rst_ram_we", k, ram_we[k], 0);
            chk("rst_ram_re", k, ram_re[k], 0);
            m_wait[k] = 0; m_last[k] = 1'b1; m_rv[k] = 1'b0;
            return;
        end
        gv = a_req[k] | b_req[k];
        if (a_req[k] && b_req[k]) wb = (k == 0) ? (m_wait[k] == LIM) : (m_last[k] == 1'b0);
        else                      wb = b_req[k];
        we = wb ? b_we[k] : a_we[k];
        ad = wb ? b_addr[k] : a_addr[k];
        wd = wb ? b_wdata[k] : a_wdata[k];
        chk("a_gnt", k, a_gnt[k], gv & ~wb);
        chk("b_gnt", k, b_gnt[k], gv & wb);
        chk("ram_cs", k, ram_cs[k], gv | m_rv[k]);
        chk("ram_we", k, ram_we[k], gv & we);
        chk("ram_re", k, ram_re[k], (gv & ~we) | m_rv[k]);
        chk("ram_a", k, ram_a[k], ad);
        chk("ram_d_in", k, ram_d_in[k], wd);
        chk("a_rvalid", k, a_rvalid[k], m_rv[k] & ~m_rb[k]);
        chk("b_rvalid", k, b_rvalid[k], m_rv[k] & m_rb[k]);
        chk("a_rdata", k, a_rdata[k], (m_rv[k] && !m_rb[k]) ? m_rdat[k] : 8'h00);
        chk("b_rdata", k, b_rdata[k], (m_rv[k] && m_rb[k]) ? m_rdat[k] : 8'h00);
        if (gv && we) m_mem[k][ad[4:0]] = wd;
        m_rv[k]   = gv & ~we;
        m_rb[k]   = wb;
        m_rdat[k] = m_mem[k][ad[4:0]];
        if (k == 0) m_wait[k] = (b_req[k] && !(gv && wb)) ? ((m_wait[k] < LIM) ? m_wait[k] + 1 : LIM) : 0;
        if (a_req[k] && b_req[k]) m_last[k] = wb;
    endtask

    task automatic tick_check();
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_check(k);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        for (int k = 0; k < 2; k++) begin
            a_req[k] = r; a_we[k] = w; a_addr[k] = ad; a_wdata[k] = d;
        end
    endtask

    task automatic set_b(input logic r, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        for (int k = 0; k < 2; k++) begin
            b_req[k] = r; b_we[k] = w; b_addr[k] = ad; b_wdata[k] = d;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_last[k] = 1'b1; m_rv[k] = 1'b0; sa[k] = 1'b0; sb[k] = 1'b0;
        end
        #2 rst_n = 1'b0;
        // A request held during reset must not be granted
        set_a(1, 0, 13'h10, '0);
        repeat (3) begin
            tick_check();
            for (int k = 0; k < 2; k++) chk("reset_a_gnt", k, a_gnt[k], 0);
        end
        set_a(0, 0, '0, '0);
        rst_n = 1'b1;
        adv();

        for (int i = 0; i < 32; i++) begin
            set_a(1, 1, AW'(i), DW'(i * 37 + 5));
            tick_check();
            adv();
        end
        set_a(1, 1, 13'h0010, 8'h5A); tick_check();
        for (int k = 0; k < 2; k++) chk("wr_5a_gnt", k, a_gnt[k], 1);
        adv();
        set_a(1, 1, 13'h0001, 8'h11); tick_check(); adv();
        set_a(1, 1, 13'h0002, 8'h22); tick_check(); adv();

        set_a(1, 0, 13'h0010, '0); tick_check();
        for (int k = 0; k < 2; k++) chk("rd_10_gnt", k, a_gnt[k], 1);
        adv();
        set_a(0, 0, '0, '0); tick_check();
        for (int k = 0; k < 2; k++) begin
            chk("rd_10_rvalid", k, a_rvalid[k], 1);
            chk("rd_10_rdata", k, a_rdata[k], 8'h5A);
            chk("rd_10_b_rvalid", k, b_rvalid[k], 0);
        end
        adv();

        set_a(1, 0, 13'h0001, '0); tick_check();
        for (int k = 0; k < 2; k++) begin
            chk("b2b_c0_a_gnt", k, a_gnt[k], 1); chk("b2b_c0_re", k, ram_re[k], 1);
        end
        adv();
        set_a(0, 0, '0, '0); set_b(1, 0, 13'h0002, '0); tick_check();
        for (int k = 0; k < 2; k++) begin
            chk("b2b_c1_b_gnt", k, b_gnt[k], 1);     chk("b2b_c1_a_rdata", k, a_rdata[k], 8'h11);
            chk("b2b_c1_a_rvalid", k, a_rvalid[k], 1); chk("b2b_c1_cs", k, ram_cs[k], 1);
            chk("b2b_c1_re", k, ram_re[k], 1);
        end
        adv();
        set_b(0, 0, '0, '0); tick_check();
        for (int k = 0; k < 2; k++) begin
            chk("b2b_c2_b_rvalid", k, b_rvalid[k], 1); chk("b2b_c2_b_rdata", k, b_rdata[k], 8'h22);
            chk("b2b_c2_a_rvalid", k, a_rvalid[k], 0); chk("b2b_c2_cs", k, ram_cs[k], 1);
            chk("b2b_c2_re", k, ram_re[k], 1);
        end
        adv();

        // Continuous contention: FIXED grants B every 4th cycle, RR alternates from A
        set_a(1, 0, 13'h0003, '0); set_b(1, 0, 13'h0004, '0);
        for (int j = 0; j < 8; j++) begin
            tick_check();
            chk("starve_b_gnt", 0, b_gnt[0], (j % 4) == 3);
            chk("rr_a_gnt", 1, a_gnt[1], (j % 2) == 0);
            adv();
        end
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0); tick_check(); adv();

        // B withdraws after 2 denied cycles; its wait streak must restart from zero
        set_a(1, 0, 13'h0006, '0); set_b(1, 1, 13'h0005, 8'hEE);
        for (int j = 0; j < 2; j++) begin
            tick_check();
            chk("wd_b_gnt", 0, b_gnt[0], 0);
            chk("wd_ram_we", 0, ram_we[0], 0);
            adv();
        end
        set_b(0, 0, '0, '0); tick_check(); adv();
        set_b(1, 1, 13'h0005, 8'hEE);
        for (int j = 0; j < 4; j++) begin
            tick_check();
            chk("wd_restart_b_gnt", 0, b_gnt[0], j == 3);
            adv();
        end
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0); tick_check(); adv();

        // Reset pulse in the return cycle of a read
        set_a(1, 0, 13'h0010, '0); tick_check(); adv();
        set_a(0, 0, '0, '0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_a_rvalid", k, a_rvalid[k], 0);
            chk("async_a_rdata", k, a_rdata[k], 0);
            chk("async_ram_cs", k, ram_cs[k], 0);
        end
        tick_check();
        rst_n = 1'b1;
        adv();
        set_a(1, 0, 13'h0010, '0); set_b(1, 0, 13'h0011, '0); tick_check();
        for (int k = 0; k < 2; k++) chk("post_rst_a_gnt", k, a_gnt[k], 1);
        adv();
        set_a(0, 0, '0, '0); set_b(0, 0, '0, '0); tick_check(); adv();

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (a_req[k] && !sa[k] && $urandom_range(15) == 0) begin
                    a_req[k] = 1'b0;
                end else if (!a_req[k] || sa[k]) begin
                    a_req[k]   = ($urandom_range(3) != 0);
                    a_we[k]    = 1'($urandom_range(1));
                    a_addr[k]  = AW'($urandom_range(31));
                    a_wdata[k] = DW'($urandom);
                end
                if (b_req[k] && !sb[k] && $urandom_range(15) == 0) begin
                    b_req[k] = 1'b0;
                end else if (!b_req[k] || sb[k]) begin
                    b_req[k]   = ($urandom_range(3) != 0);
                    b_we[k]    = 1'($urandom_range(1));
                    b_addr[k]  = AW'($urandom_range(31));
                    b_wdata[k] = DW'($urandom);
                end
            end
            tick_check();
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
